// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtracter.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/Fullsubtracter_stru.sv
// Combinational full-subtracter cell: d = x - y - bin, b = borrow out.
module Fullsubtracter_stru (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic b
);

    logic x_xor_y;

    assign x_xor_y = x ^ y;
    assign d       = x_xor_y ^ bin;
    assign b       = (~x & y) | (~x_xor_y & bin);

endmodule

// File: rtl/serial_subtracter.sv
// Bit-serial unsigned subtracter: one full-subtracter cell, one bit per clock, LSB first.
//   state | meaning
//   IDLE  | waiting for start, operands captured on accept
//   SHIFT | one operand bit pair through the cell per clock
//   DONE  | one-cycle result-valid pulse
module serial_subtracter
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   diff_sr;
    logic [WIDTH-1:0]   diff_next;
    logic [CNT_W-1:0]   cnt;
    logic               borrow_q;
    logic               cell_d;
    logic               cell_bo;
    logic               last_bit;

    Fullsubtracter_stru u_cell (
        .x   (a_reg[0]),
        .y   (b_reg[0]),
        .bin (borrow_q),
        .d   (cell_d),
        .b   (cell_bo)
    );

    assign diff_next = {cell_d, diff_sr[WIDTH-1:1]};
    assign last_bit  = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            SHIFT: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Counter holds at its last value instead of wrapping on the final bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            diff_sr    <= '0;
            cnt        <= '0;
            borrow_q   <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        diff_sr  <= '0;
                        cnt      <= '0;
                        borrow_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    a_reg    <= a_reg >> 1;
                    b_reg    <= b_reg >> 1;
                    diff_sr  <= diff_next;
                    borrow_q <= cell_bo;
                    if (last_bit) begin
                        diff       <= diff_next;
                        borrow_out <= cell_bo;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtracter.sv
// Self-checking bench: directed and random 8-bit operations plus an exhaustive 4-bit sweep.
module tb_serial_subtracter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start8, start4;
    logic [7:0] a8, b8, diff8;
    logic [3:0] a4, b4, diff4;
    logic       busy8, done8, bo8;
    logic       busy4, done4, bo4;

    int n_total = 0;
    int n_bad   = 0;
    logic [7:0] last_d8;
    logic       last_b8;

    always #5 clk = ~clk;

    serial_subtracter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    serial_subtracter #(.WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned ref_diff(input int w, input int unsigned x, input int unsigned y);
        int unsigned m;
        m = 32'd1 << w;
        return (x + m - y) % m;
    endfunction

    function automatic int unsigned ref_borrow(input int unsigned x, input int unsigned y);
        return (x < y) ? 32'd1 : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit operation with full cycle-by-cycle timing checks; meddle holds
    // start high with other operands through SHIFT and DONE.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit meddle);
        logic [7:0] exp_d;
        logic       exp_b;
        exp_d  = 8'(ref_diff(8, 32'(av), 32'(bv)));
        exp_b  = 1'(ref_borrow(32'(av), 32'(bv)));
        a8     = av;
        b8     = bv;
        start8 = 1'b1;
        tick();
        start8 = meddle;
        if (meddle) begin
            a8 = 8'hFF;
            b8 = 8'h00;
        end else begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
        end
        check_val("busy_rise", 32'(busy8), 32'd1);
        check_val("done_early", 32'(done8), 32'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check_val("busy_shift", 32'(busy8), 32'd1);
            check_val("done_early", 32'(done8), 32'd0);
            check_val("diff_hold", 32'(diff8), 32'(last_d8));
        end
        tick();
        check_val("done_pulse", 32'(done8), 32'd1);
        check_val("busy_done", 32'(busy8), 32'd1);
        check_val("diff", 32'(diff8), 32'(exp_d));
        check_val("borrow", 32'(bo8), 32'(exp_b));
        last_d8 = exp_d;
        last_b8 = exp_b;
        tick();
        start8 = 1'b0;
        check_val("busy_fall", 32'(busy8), 32'd0);
        check_val("done_fall", 32'(done8), 32'd0);
        for (int i = 0; i < (meddle ? 12 : 1); i++) begin
            tick();
            check_val("no_extra_done", 32'(done8), 32'd0);
            check_val("idle_busy", 32'(busy8), 32'd0);
            check_val("diff_hold", 32'(diff8), 32'(last_d8));
            check_val("borrow_hold", 32'(bo8), 32'(last_b8));
        end
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv);
        int seen;
        seen   = 0;
        a4     = av;
        b4     = bv;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        a4     = ~av;
        b4     = ~bv;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done4) begin
                seen++;
                check_val("w4_latency", 32'(i), 32'd3);
                check_val("w4_diff", 32'(diff4), ref_diff(4, 32'(av), 32'(bv)));
                check_val("w4_borrow", 32'(bo4), ref_borrow(32'(av), 32'(bv)));
            end
        end
        check_val("w4_done_count", 32'(seen), 32'd1);
    endtask

    initial begin
        int cyc;
        logic [7:0] qa [3];
        logic [7:0] qb [3];

        reset_n = 1'b0;
        start8  = 1'b0;
        start4  = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        last_d8 = '0;
        last_b8 = 1'b0;
        tick();
        tick();
        check_val("rst_busy", 32'(busy8), 32'd0);
        check_val("rst_done", 32'(done8), 32'd0);
        check_val("rst_diff", 32'(diff8), 32'd0);
        check_val("rst_borrow", 32'(bo8), 32'd0);
        check_val("rst_busy4", 32'(busy4), 32'd0);
        reset_n = 1'b1;
        tick();

        op8(8'h5A, 8'h23, 1'b0);
        op8(8'h80, 8'h80, 1'b0);
        op8(8'h10, 8'h01, 1'b1);
        op8(8'h00, 8'h01, 1'b0);

        // Abort with reset on the 4th SHIFT edge; previous result must be cleared.
        a8 = 8'h55; b8 = 8'h11; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_val("abort_busy", 32'(busy8), 32'd0);
        check_val("abort_done", 32'(done8), 32'd0);
        check_val("abort_diff", 32'(diff8), 32'd0);
        check_val("abort_borrow", 32'(bo8), 32'd0);
        last_d8 = '0;
        last_b8 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_val("abort_no_done", 32'(done8), 32'd0);
        end
        op8(8'h09, 8'h03, 1'b0);

        for (int n = 0; n < 30; n++)
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

        // Back-to-back with start held high; operands for the next accept set at each done.
        for (int j = 0; j < 3; j++) begin
            qa[j] = 8'($urandom);
            qb[j] = 8'($urandom);
        end
        a8 = qa[0]; b8 = qb[0]; start8 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            cyc = 0;
            do begin
                tick();
                cyc++;
                if (!done8) check_val("b2b_diff_hold", 32'(diff8), 32'(last_d8));
            end while (!done8 && cyc < 30);
            check_val("b2b_done_seen", 32'(done8), 32'd1);
            check_val("b2b_spacing", 32'(cyc), (j == 0) ? 32'd9 : 32'd10);
            check_val("b2b_diff", 32'(diff8), ref_diff(8, 32'(qa[j]), 32'(qb[j])));
            check_val("b2b_borrow", 32'(bo8), ref_borrow(32'(qa[j]), 32'(qb[j])));
            last_d8 = 8'(ref_diff(8, 32'(qa[j]), 32'(qb[j])));
            if (j < 2) begin
                a8 = qa[j+1];
                b8 = qb[j+1];
            end else begin
                start8 = 1'b0;
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            check_val("b2b_tail_done", 32'(done8), 32'd0);
        end

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                op4(4'(x), 4'(y));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
